// File: rtl/ioexp_host.sv
// Bus master for an 8243-style I/O expander: frames one address nibble and one
// data nibble per command on P2, strobed by PROG, with registered bus outputs.
module ioexp_host #(
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int PULSE_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_port,
   input  logic [3:0] cmd_data,
   output logic       rsp_valid,
   output logic [3:0] rsp_data,
   output logic       busy,
   input  logic [3:0] p2i,
   output logic [3:0] p2o,
   output logic       p2_oe,
   output logic       prog_n
);

   localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int MAX_C  = (MAX_SH > PULSE_CYC) ? MAX_SH : PULSE_CYC;
   localparam int CNT_W  = ($clog2(MAX_C) < 1) ? 1 : $clog2(MAX_C);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

   if (SETUP_CYC < 1 || HOLD_CYC < 1 || PULSE_CYC < 2) begin : g_bad_params
      $error("ioexp_host: SETUP_CYC>=1, HOLD_CYC>=1, PULSE_CYC>=2 required");
   end

   typedef enum logic [2:0] {IDLE, ADDR, AHOLD, DATA, RISE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             accept;
   logic [1:0]       op_q;
   logic [1:0]       port_q;
   logic [3:0]       data_q;
   logic             is_read;
   logic [3:0]       addr_nib;
   logic             prog_n_nx;
   logic             p2_oe_nx;
   logic [3:0]       p2o_nx;
   logic             rsp_valid_nx;
   logic             sample;

   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;
   assign is_read   = (op_q == 2'b00);
   // On the accept edge the latches are not yet loaded, so address comes straight from the port.
   assign addr_nib  = accept ? {cmd_op, cmd_port} : {op_q, port_q};

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      accept       = 1'b0;
      prog_n_nx    = 1'b1;
      p2_oe_nx     = 1'b0;
      p2o_nx       = 4'h0;
      rsp_valid_nx = 1'b0;
      sample       = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept   = 1'b1;
               state_nx = ADDR;
               cnt_nx   = SETUP_LD;
            end
         end
         ADDR: begin
            if (cnt == '0) begin
               state_nx = AHOLD;
               cnt_nx   = HOLD_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         AHOLD: begin
            if (cnt == '0) begin
               state_nx = DATA;
               cnt_nx   = PULSE_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               state_nx = RISE;
               cnt_nx   = HOLD_LD;
               sample   = is_read;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RISE: begin
            if (cnt == '0) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      // Bus outputs are registered, so they are derived from the state being entered.
      case (state_nx)
         ADDR: begin
            p2_oe_nx = 1'b1;
            p2o_nx   = addr_nib;
         end
         AHOLD: begin
            prog_n_nx = 1'b0;
            p2_oe_nx  = 1'b1;
            p2o_nx    = addr_nib;
         end
         DATA: begin
            prog_n_nx = 1'b0;
            if (!is_read) begin
               p2_oe_nx = 1'b1;
               p2o_nx   = data_q;
            end
         end
         RISE: begin
            if (!is_read) begin
               p2_oe_nx = 1'b1;
               p2o_nx   = data_q;
            end
            rsp_valid_nx = sample;
         end
         default: begin
            prog_n_nx = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         prog_n    <= 1'b1;
         p2_oe     <= 1'b0;
         p2o       <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_data  <= 4'h0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         prog_n    <= prog_n_nx;
         p2_oe     <= p2_oe_nx;
         p2o       <= p2o_nx;
         rsp_valid <= rsp_valid_nx;
         if (sample) begin
            rsp_data <= p2i;
         end
      end
   end

   // Command fields are frozen at accept; later cmd_* activity is ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= cmd_op;
         port_q <= cmd_port;
         data_q <= cmd_data;
      end
   end

endmodule

// File: tb/tb_ioexp_host.sv
// Directed bench for ioexp_host: default-timing instance plus a minimum-timing
// instance, checked cycle by cycle against hand-derived waveforms.
module tb_ioexp_host;

   logic       clk;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op, cmd_port;
   logic [3:0] cmd_data;
   logic       rsp_valid;
   logic [3:0] rsp_data;
   logic       busy;
   logic [3:0] p2i, p2o;
   logic       p2_oe, prog_n;

   logic       b_cmd_valid, b_cmd_ready;
   logic [1:0] b_cmd_op, b_cmd_port;
   logic [3:0] b_cmd_data;
   logic       b_rsp_valid;
   logic [3:0] b_rsp_data;
   logic       b_busy;
   logic [3:0] b_p2i, b_p2o;
   logic       b_p2_oe, b_prog_n;

   int checks = 0;
   int errors = 0;

   ioexp_host dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .p2i(p2i), .p2o(p2o), .p2_oe(p2_oe), .prog_n(prog_n)
   );

   ioexp_host #(.SETUP_CYC(1), .HOLD_CYC(1), .PULSE_CYC(2)) dut_b (
      .clk(clk), .rst(rst),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_op(b_cmd_op), .cmd_port(b_cmd_port), .cmd_data(b_cmd_data),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
      .p2i(b_p2i), .p2o(b_p2o), .p2_oe(b_p2_oe), .prog_n(b_prog_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_port = 2'b10; cmd_data = 4'hA;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (prog_n !== 1'b1) begin errors++; $display("FAIL rst_prog_n got %b want 1", prog_n); end
      checks++; if (p2_oe !== 1'b0) begin errors++; $display("FAIL rst_p2_oe got %b want 0", p2_oe); end
      checks++; if (p2o !== 4'h0) begin errors++; $display("FAIL rst_p2o got %h want 0", p2o); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (b_prog_n !== 1'b1 || b_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_b got prog_n=%b ready=%b want 1,1", b_prog_n, b_cmd_ready); end
      cmd_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_no_valid_ready got %b want 1", cmd_ready); end
   endtask

   // Read with the bus value changing around the sample point; only cycle 8's value may land.
   task automatic test_sample_point();
      logic exp_oe;
      cmd_op = 2'b00; cmd_port = 2'b00; cmd_data = 4'h0; cmd_valid = 1'b1; p2i = 4'h0;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c == 1) cmd_valid = 1'b0;
         if (c >= 5 && c <= 7) p2i = 4'h3;
         else if (c == 8) p2i = 4'h9;
         else if (c >= 9) p2i = 4'h5;
         exp_oe = (c <= 4);
         checks++; if (p2_oe !== exp_oe) begin errors++; $display("FAIL smp_p2_oe c=%0d got %b want %b", c, p2_oe, exp_oe); end
         checks++; if (rsp_valid !== (c == 9)) begin errors++; $display("FAIL smp_rsp_valid c=%0d got %b want %b", c, rsp_valid, (c == 9)); end
         if (c == 8) begin
            checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL smp_rsp_early c=%0d got %h want 0", c, rsp_data); end
         end
         if (c >= 9) begin
            checks++; if (rsp_data !== 4'h9) begin errors++; $display("FAIL smp_rsp_data c=%0d got %h want 9", c, rsp_data); end
         end
      end
   endtask

   task automatic test_write();
      logic       exp_oe, exp_pn;
      logic [3:0] exp_p2o;
      cmd_op = 2'b01; cmd_port = 2'b10; cmd_data = 4'hA; cmd_valid = 1'b1; p2i = 4'h0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_c0 got %b want 1", cmd_ready); end
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            cmd_valid = 1'b0; cmd_op = 2'b11; cmd_port = 2'b00; cmd_data = 4'h5;
         end
         exp_oe  = (c <= 10);
         exp_pn  = !(c >= 3 && c <= 8);
         exp_p2o = (c <= 4) ? 4'h6 : (c <= 10) ? 4'hA : 4'h0;
         checks++; if (p2_oe !== exp_oe) begin errors++; $display("FAIL wr_p2_oe c=%0d got %b want %b", c, p2_oe, exp_oe); end
         checks++; if (prog_n !== exp_pn) begin errors++; $display("FAIL wr_prog_n c=%0d got %b want %b", c, prog_n, exp_pn); end
         checks++; if (p2o !== exp_p2o) begin errors++; $display("FAIL wr_p2o c=%0d got %h want %h", c, p2o, exp_p2o); end
         checks++; if (cmd_ready !== (c == 11)) begin errors++; $display("FAIL wr_cmd_ready c=%0d got %b want %b", c, cmd_ready, (c == 11)); end
         checks++; if (busy !== (c != 11)) begin errors++; $display("FAIL wr_busy c=%0d got %b want %b", c, busy, (c != 11)); end
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_valid c=%0d got %b want 0", c, rsp_valid); end
      end
   endtask

   task automatic test_reset_mid_write();
      cmd_op = 2'b01; cmd_port = 2'b10; cmd_data = 4'hA; cmd_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) cmd_valid = 1'b0;
      end
      checks++; if (prog_n !== 1'b0 || p2_oe !== 1'b1) begin errors++; $display("FAIL mrst_pre got prog_n=%b oe=%b want 0,1", prog_n, p2_oe); end
      #2 rst = 1'b1;
      #1;
      checks++; if (prog_n !== 1'b1) begin errors++; $display("FAIL mrst_prog_n got %b want 1", prog_n); end
      checks++; if (p2_oe !== 1'b0) begin errors++; $display("FAIL mrst_p2_oe got %b want 0", p2_oe); end
      checks++; if (p2o !== 4'h0) begin errors++; $display("FAIL mrst_p2o got %h want 0", p2o); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mrst_cmd_ready got %b want 1", cmd_ready); end
      checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL mrst_rsp_data got %h want 0", rsp_data); end
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_port = 2'b11; cmd_data = 4'h7;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1 || p2_oe !== 1'b0) begin errors++; $display("FAIL mrst_held got ready=%b oe=%b want 1,0", cmd_ready, p2_oe); end
      cmd_op = 2'b00; cmd_port = 2'b01; cmd_data = 4'h0;
      rst = 1'b0;
   endtask

   task automatic test_read();
      logic       exp_oe, exp_pn;
      logic [3:0] exp_p2o;
      cmd_op = 2'b00; cmd_port = 2'b01; cmd_data = 4'h0; cmd_valid = 1'b1; p2i = 4'h0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_c0 got %b want 1", cmd_ready); end
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c == 1) cmd_valid = 1'b0;
         if (c >= 5) p2i = 4'h9;
         exp_oe  = (c <= 4);
         exp_pn  = !(c >= 3 && c <= 8);
         exp_p2o = (c <= 4) ? 4'h1 : 4'h0;
         checks++; if (p2_oe !== exp_oe) begin errors++; $display("FAIL rd_p2_oe c=%0d got %b want %b", c, p2_oe, exp_oe); end
         checks++; if (prog_n !== exp_pn) begin errors++; $display("FAIL rd_prog_n c=%0d got %b want %b", c, prog_n, exp_pn); end
         checks++; if (p2o !== exp_p2o) begin errors++; $display("FAIL rd_p2o c=%0d got %h want %h", c, p2o, exp_p2o); end
         checks++; if (rsp_valid !== (c == 9)) begin errors++; $display("FAIL rd_rsp_valid c=%0d got %b want %b", c, rsp_valid, (c == 9)); end
         checks++; if (cmd_ready !== (c == 11)) begin errors++; $display("FAIL rd_cmd_ready c=%0d got %b want %b", c, cmd_ready, (c == 11)); end
         if (c >= 9) begin
            checks++; if (rsp_data !== 4'h9) begin errors++; $display("FAIL rd_rsp_data c=%0d got %h want 9", c, rsp_data); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_oe, exp_pn;
      logic [3:0] exp_p2o;
      cmd_op = 2'b01; cmd_port = 2'b00; cmd_data = 4'h3; cmd_valid = 1'b1; p2i = 4'h0;
      for (int c = 1; c <= 22; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            cmd_op = 2'b00; cmd_port = 2'b10; cmd_data = 4'hC;
         end
         if (c == 12) cmd_valid = 1'b0;
         if (c >= 16) p2i = 4'h6;
         exp_oe  = (c <= 10) || (c >= 12 && c <= 15);
         exp_pn  = !((c >= 3 && c <= 8) || (c >= 14 && c <= 19));
         exp_p2o = (c <= 4) ? 4'h4 : (c <= 10) ? 4'h3 : (c >= 12 && c <= 15) ? 4'h2 : 4'h0;
         checks++; if (p2_oe !== exp_oe) begin errors++; $display("FAIL b2b_p2_oe c=%0d got %b want %b", c, p2_oe, exp_oe); end
         checks++; if (prog_n !== exp_pn) begin errors++; $display("FAIL b2b_prog_n c=%0d got %b want %b", c, prog_n, exp_pn); end
         checks++; if (p2o !== exp_p2o) begin errors++; $display("FAIL b2b_p2o c=%0d got %h want %h", c, p2o, exp_p2o); end
         checks++; if (cmd_ready !== (c == 11 || c == 22)) begin errors++; $display("FAIL b2b_cmd_ready c=%0d got %b want %b", c, cmd_ready, (c == 11 || c == 22)); end
         checks++; if (rsp_valid !== (c == 20)) begin errors++; $display("FAIL b2b_rsp_valid c=%0d got %b want %b", c, rsp_valid, (c == 20)); end
         if (c >= 20) begin
            checks++; if (rsp_data !== 4'h6) begin errors++; $display("FAIL b2b_rsp_data c=%0d got %h want 6", c, rsp_data); end
         end
      end
   endtask

   task automatic test_min_params_or();
      logic       exp_oe, exp_pn;
      logic [3:0] exp_p2o;
      b_cmd_op = 2'b10; b_cmd_port = 2'b11; b_cmd_data = 4'hF; b_cmd_valid = 1'b1;
      checks++; if (b_cmd_ready !== 1'b1) begin errors++; $display("FAIL min_ready_c0 got %b want 1", b_cmd_ready); end
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) b_cmd_valid = 1'b0;
         exp_oe  = (c <= 5);
         exp_pn  = !(c >= 2 && c <= 4);
         exp_p2o = (c <= 2) ? 4'hB : (c <= 5) ? 4'hF : 4'h0;
         checks++; if (b_p2_oe !== exp_oe) begin errors++; $display("FAIL min_p2_oe c=%0d got %b want %b", c, b_p2_oe, exp_oe); end
         checks++; if (b_prog_n !== exp_pn) begin errors++; $display("FAIL min_prog_n c=%0d got %b want %b", c, b_prog_n, exp_pn); end
         checks++; if (b_p2o !== exp_p2o) begin errors++; $display("FAIL min_p2o c=%0d got %h want %h", c, b_p2o, exp_p2o); end
         checks++; if (b_cmd_ready !== (c == 6)) begin errors++; $display("FAIL min_cmd_ready c=%0d got %b want %b", c, b_cmd_ready, (c == 6)); end
         checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL min_rsp_valid c=%0d got %b want 0", c, b_rsp_valid); end
      end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_port = 2'b00; cmd_data = 4'h0; p2i = 4'h0;
      b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_port = 2'b00; b_cmd_data = 4'h0; b_p2i = 4'h0;
      test_reset();
      test_sample_point();
      test_write();
      test_reset_mid_write();
      test_read();
      test_back_to_back();
      test_min_params_or();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
